flag_selector: RTL

- Upstream control stage that produces the 7-bit flag selector consumed by the flag index/colour mux.
- Turns two raw push-buttons (next/prev) into debounced, auto-repeating step events, with optional timed slideshow advance.
- Updates only on the frame-start pulse from the VGA timing generator, so the flag never changes mid-frame.
- Wraps using the flag count (max) reported by the index block.

---
 rtl/flag_selector_pkg.sv | 5 +
 rtl/flag_button.sv | 55 +++++
 rtl/flag_selector.sv | 58 +++++
 3 files changed

// File: rtl/flag_selector_pkg.sv
// flag_selector_pkg: shared selector width and button state encoding
package flag_selector_pkg;
  localparam int SEL_W = 7;
  typedef enum logic [1:0] {RELEASED, ARMED, HELD, REPEATING} btn_state_e;
endpackage

// File: rtl/flag_button.sv
// flag_button: synchronized push-button to debounced auto-repeating frame-rate step events
module flag_button
  import flag_selector_pkg::*;
#(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic btn,
  output logic ev
);
  logic sync1_q, sync2_q;
  btn_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev      = 1'b0;
    if (frame_start) begin
      if (!sync2_q) state_d = RELEASED;
      else case (state_q)
        RELEASED: state_d = ARMED;
        ARMED: begin
          state_d = HELD;
          ev      = 1'b1;
          cnt_d   = '0;
        end
        HELD: begin
          ev      = cnt_q == 6'(REPEAT_DELAY - 1);
          cnt_d   = ev ? '0 : cnt_q + 6'd1;
          state_d = ev ? REPEATING : HELD;
        end
        default: begin
          ev    = cnt_q == 6'(REPEAT_RATE - 1);
          cnt_d = ev ? '0 : cnt_q + 6'd1;
        end
      endcase
    end
  end
endmodule

// File: rtl/flag_selector.sv
// flag_selector: frame-synchronous flag index from next/prev buttons and slideshow timer
module flag_selector
  import flag_selector_pkg::*;
#(
  parameter int AUTO_FRAMES  = 300,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  input  logic [SEL_W-1:0] max,
  output logic [SEL_W-1:0] selector,
  output logic             changed
);
  logic next_ev, prev_ev, manual, auto_fire;
  logic [SEL_W-1:0] sel_q, sel_d, inc, dec;
  logic [8:0] auto_q, auto_d;
  logic changed_q, changed_d;
  flag_button #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_next (
    .clk(clk), .rst(rst), .frame_start(frame_start), .btn(btn_next), .ev(next_ev)
  );
  flag_button #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_prev (
    .clk(clk), .rst(rst), .frame_start(frame_start), .btn(btn_prev), .ev(prev_ev)
  );
  always_comb begin
    manual    = next_ev | prev_ev;
    auto_fire = auto_en && !manual && auto_q == 9'(AUTO_FRAMES - 1);
    auto_d    = (!auto_en || manual) ? '0 :
                !frame_start         ? auto_q :
                auto_fire            ? '0 : auto_q + 9'd1;
    inc       = (sel_q == max) ? '0 : sel_q + 7'd1;
    dec       = (sel_q == '0) ? max : sel_q - 7'd1;
    sel_d     = !frame_start          ? sel_q :
                sel_q > max           ? '0 :
                (next_ev && prev_ev)  ? sel_q :
                next_ev               ? inc :
                prev_ev               ? dec :
                auto_fire             ? inc : sel_q;
    changed_d = sel_d != sel_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      auto_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      auto_q    <= auto_d;
      changed_q <= changed_d;
    end
  end
  assign selector = sel_q;
  assign changed  = changed_q;
endmodule
